// File: rtl/carryskip_pipe_adder.sv
// ---------------------------------------------------------------------------
// carryskip_pipe_adder
//
// Pipelined, parametrised carry-skip adder/subtractor. The operands are split
// into NBLK = WIDTH/BLOCK skip blocks. Each pipeline stage resolves exactly one
// block, so a beat reaches the output NBLK cycles after it is accepted. Both
// sides use a valid/ready handshake, and backpressure from the output stalls
// the whole pipeline.
//
// Parameters:
//   WIDTH  operand/sum width in bits (must be a multiple of BLOCK)
//   BLOCK  skip-block width in bits (1..WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; drops every in-flight beat
//   in_valid   operand beat valid
//   in_ready   pipeline can take a beat this cycle
//   a, b       operands
//   ci         carry in (ignored in subtract mode)
//   sub        0: s = a + b + ci, 1: s = a - b
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   s          sum / difference (modulo 2^WIDTH)
//   co         carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
//   skip       bit k set when block k was all-propagate and its carry
//              took the skip path
// ---------------------------------------------------------------------------
module carryskip_pipe_adder #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   ci,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       s,
    output logic                   co,
    output logic                   ovf,
    output logic [WIDTH/BLOCK-1:0] skip
);

    localparam int NBLK = WIDTH / BLOCK;

    // A width that does not split into whole blocks would leave bits that no
    // stage ever resolves, so refuse to elaborate.
    if ((BLOCK < 1) || (BLOCK > WIDTH) || ((WIDTH % BLOCK) != 0)) begin : g_param_check
        $error("carryskip_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Result of resolving one block: its sum bits, the carry handed to the
    // next block, and whether the block was all-propagate.
    typedef struct packed {
        logic [BLOCK-1:0] sum;
        logic             carry;
        logic             prop;
    } blk_res_t;

    // Ripple through one block while also forming the group-propagate term.
    // When the whole block propagates, the outgoing carry is taken straight
    // from the incoming carry (the skip path) instead of the ripple chain.
    function automatic blk_res_t resolve_block(
        input logic [BLOCK-1:0] blk_a,
        input logic [BLOCK-1:0] blk_b,
        input logic             cin
    );
        blk_res_t res;
        logic     rc;
        logic     x;
        rc       = cin;
        res.sum  = '0;
        res.prop = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            x          = blk_a[i] ^ blk_b[i];
            res.sum[i] = x ^ rc;
            rc         = (blk_a[i] & blk_b[i]) | (x & rc);
            res.prop   = res.prop & x;
        end
        res.carry = res.prop ? cin : rc;
        return res;
    endfunction

    // Per-stage registers. Every stage carries the full prepared operands so
    // later blocks can still be resolved; the partial sum fills in one block
    // per stage.
    logic             st_valid [NBLK];
    logic [WIDTH-1:0] st_a     [NBLK];
    logic [WIDTH-1:0] st_b     [NBLK];
    logic [WIDTH-1:0] st_s     [NBLK];
    logic             st_c     [NBLK];
    logic [NBLK-1:0]  st_skip  [NBLK];

    // What each stage would load on an advancing edge.
    logic             src_valid [NBLK];
    logic [WIDTH-1:0] src_a     [NBLK];
    logic [WIDTH-1:0] src_b     [NBLK];
    logic [WIDTH-1:0] src_s     [NBLK];
    logic             src_c     [NBLK];
    logic [NBLK-1:0]  src_skip  [NBLK];

    logic [WIDTH-1:0] nxt_s    [NBLK];
    logic             nxt_c    [NBLK];
    logic [NBLK-1:0]  nxt_skip [NBLK];
    blk_res_t         blk_res  [NBLK];

    logic advance;

    // The only thing that can stop the pipeline is a result sitting at the
    // output that downstream refuses; every stage moves in lockstep otherwise,
    // which is also when a new beat can enter.
    assign advance  = !(st_valid[NBLK-1] && !out_ready);
    assign in_ready = advance;

    // Stage inputs. Stage 0 takes the port operands after subtract
    // preparation (b inverted, carry forced to 1); later stages take the
    // previous stage's registers.
    always_comb begin
        src_valid[0] = in_valid;
        src_a[0]     = a;
        src_b[0]     = sub ? ~b : b;
        src_c[0]     = sub ? 1'b1 : ci;
        src_s[0]     = '0;
        src_skip[0]  = '0;
        for (int k = 1; k < NBLK; k++) begin
            src_valid[k] = st_valid[k-1];
            src_a[k]     = st_a[k-1];
            src_b[k]     = st_b[k-1];
            src_c[k]     = st_c[k-1];
            src_s[k]     = st_s[k-1];
            src_skip[k]  = st_skip[k-1];
        end
    end

    // Each stage resolves its own block and merges the new sum bits and skip
    // flag into what the beat already carries.
    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            blk_res[k] = resolve_block(src_a[k][k*BLOCK +: BLOCK],
                                       src_b[k][k*BLOCK +: BLOCK],
                                       src_c[k]);
            nxt_s[k]                     = src_s[k];
            nxt_s[k][k*BLOCK +: BLOCK]   = blk_res[k].sum;
            nxt_skip[k]                  = src_skip[k];
            nxt_skip[k][k]               = blk_res[k].prop;
            nxt_c[k]                     = blk_res[k].carry;
        end
    end

    // Pipeline registers. Valid bits move on every advancing edge so bubbles
    // travel as invalid stages. Data is only loaded behind a valid beat,
    // which keeps the final stage (and so the outputs) holding the last
    // result after it has been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) begin
                st_valid[k] <= 1'b0;
                st_a[k]     <= '0;
                st_b[k]     <= '0;
                st_s[k]     <= '0;
                st_c[k]     <= 1'b0;
                st_skip[k]  <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < NBLK; k++) begin
                st_valid[k] <= src_valid[k];
                if (src_valid[k]) begin
                    st_a[k]    <= src_a[k];
                    st_b[k]    <= src_b[k];
                    st_s[k]    <= nxt_s[k];
                    st_c[k]    <= nxt_c[k];
                    st_skip[k] <= nxt_skip[k];
                end
            end
        end
    end

    // Outputs come straight from the last stage. Overflow uses the prepared
    // operand b, so the same rule covers both add and subtract.
    assign out_valid = st_valid[NBLK-1];
    assign s         = st_s[NBLK-1];
    assign co        = st_c[NBLK-1];
    assign skip      = st_skip[NBLK-1];
    assign ovf       = (st_a[NBLK-1][WIDTH-1] == st_b[NBLK-1][WIDTH-1]) &&
                       (st_s[NBLK-1][WIDTH-1] != st_a[NBLK-1][WIDTH-1]);

endmodule

// File: tb/tb_carryskip_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_carryskip_pipe_adder
//
// Drives an 8-bit/4-bit-block instance through a scoreboard: every accepted
// beat pushes its expected result, every consumed result pops and compares.
// A 16-bit/4-bit-block instance confirms the latency scales with NBLK.
// ---------------------------------------------------------------------------
module tb_carryskip_pipe_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
    logic [7:0] a, b, s;
    logic [1:0] skip;

    logic        w_in_valid, w_in_ready, w_ci, w_sub, w_out_valid, w_out_ready, w_co, w_ovf;
    logic [15:0] w_a, w_b, w_s;
    logic [3:0]  w_skip;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       ovf;
        logic [1:0] skip;
    } res_t;

    res_t sb[$];

    always #5 clk = ~clk;

    carryskip_pipe_adder #(.WIDTH(8), .BLOCK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf), .skip(skip)
    );

    carryskip_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .ci(w_ci), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .s(w_s), .co(w_co), .ovf(w_ovf), .skip(w_skip)
    );

    // Reference arithmetic for the 8-bit instance, written from the
    // arithmetic definition rather than the block structure.
    function automatic res_t model8(input logic [7:0] ma, input logic [7:0] mb,
                                    input logic mci, input logic msub);
        logic [7:0] bp;
        logic       c0;
        logic [8:0] full;
        res_t       r;
        bp        = msub ? ~mb : mb;
        c0        = msub ? 1'b1 : mci;
        full      = {1'b0, ma} + {1'b0, bp} + {8'd0, c0};
        r.s       = full[7:0];
        r.co      = full[8];
        r.ovf     = (ma[7] == bp[7]) && (full[7] != ma[7]);
        r.skip[0] = &(ma[3:0] ^ bp[3:0]);
        r.skip[1] = &(ma[7:4] ^ bp[7:4]);
        return r;
    endfunction

    // One cycle on the 8-bit instance, starting and ending at a falling
    // edge: drive inputs, report acceptance and any result consumed at the
    // coming rising edge, and push the expectation for an accepted beat.
    task automatic tick(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tci, input logic tsub, input logic rdy,
                        output logic acc, output logic got, output res_t obs);
        in_valid  = v;
        a         = ta;
        b         = tb;
        ci        = tci;
        sub       = tsub;
        out_ready = rdy;
        #1;
        acc = v && in_ready;
        got = out_valid && rdy;
        obs = {s, co, ovf, skip};
        if (acc) sb.push_back(model8(ta, tb, tci, tsub));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_ci = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if ({s, co, ovf, skip} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got s=%0d co=%b ovf=%b skip=%b expected all 0", s, co, ovf, skip);
        end
        checks++;
        if (w_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wide_out_valid: got %b expected 0", w_out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic acc, got;
        res_t obs, expv;
        int   lat;
        sb.delete();
        tick(1'b1, 8'd5, 8'd10, 1'b1, 1'b0, 1'b1, acc, got, obs);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_accept: got %b expected 1", acc);
        end
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc, got, obs);
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected 2", lat);
        end
        tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc, got, obs);
        expv = '{s: 8'd16, co: 1'b0, ovf: 1'b0, skip: 2'b01};
        checks++;
        if (!got || obs !== expv) begin
            errors++;
            $display("[TB] FAIL basic_result: got valid=%b s=%0d co=%b ovf=%b skip=%b expected s=16 co=0 ovf=0 skip=01",
                     got, obs.s, obs.co, obs.ovf, obs.skip);
        end
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vc [4];
        logic       acc, got;
        res_t       obs, expv;
        int         idx, sel, outs, first, last, cyc;
        va = '{8'd100, 8'd127, 8'd125, 8'd245};
        vb = '{8'd200, 8'd127, 8'd110, 8'd2};
        vc = '{1'b0, 1'b1, 1'b1, 1'b0};
        sb.delete();
        idx = 0; outs = 0; first = -1; last = -1; cyc = 0;
        while ((idx < 4 || sb.size() > 0) && cyc < 20) begin
            sel = (idx < 4) ? idx : 0;
            tick(idx < 4, va[sel], vb[sel], vc[sel], 1'b0, 1'b1, acc, got, obs);
            if (acc) idx++;
            if (got) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_unexpected: got s=%0d expected no output", obs.s);
                end else begin
                    expv = sb.pop_front();
                    if (obs !== expv) begin
                        errors++;
                        $display("[TB] FAIL b2b_result: got s=%0d co=%b ovf=%b skip=%b expected s=%0d co=%b ovf=%b skip=%b",
                                 obs.s, obs.co, obs.ovf, obs.skip, expv.s, expv.co, expv.ovf, expv.skip);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                outs++;
            end
            cyc++;
        end
        checks++;
        if (outs != 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d results expected 4", outs);
        end
        checks++;
        if (last - first != 3) begin
            errors++;
            $display("[TB] FAIL b2b_throughput: got span %0d cycles expected 3", last - first);
        end
    endtask

    task automatic test_skip;
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic       vc [2];
        logic       acc, got;
        res_t       obs, expv;
        int         idx, sel, outs, cyc;
        va = '{8'h0F, 8'h0F};
        vb = '{8'hF0, 8'h00};
        vc = '{1'b1, 1'b0};
        sb.delete();
        idx = 0; outs = 0; cyc = 0;
        while ((idx < 2 || sb.size() > 0) && cyc < 20) begin
            sel = (idx < 2) ? idx : 0;
            tick(idx < 2, va[sel], vb[sel], vc[sel], 1'b0, 1'b1, acc, got, obs);
            if (acc) idx++;
            if (got) begin
                checks++;
                expv = (sb.size() > 0) ? sb.pop_front() : '1;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL skip_result: got s=%h co=%b skip=%b expected s=%h co=%b skip=%b",
                             obs.s, obs.co, obs.skip, expv.s, expv.co, expv.skip);
                end
                outs++;
            end
            cyc++;
        end
        checks++;
        if (outs != 2) begin
            errors++;
            $display("[TB] FAIL skip_count: got %0d results expected 2", outs);
        end
    endtask

    task automatic test_subtract;
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic       acc, got;
        res_t       obs, expv;
        int         idx, sel, outs, cyc;
        va = '{8'd37, 8'h80};
        vb = '{8'd48, 8'd1};
        sb.delete();
        idx = 0; outs = 0; cyc = 0;
        while ((idx < 2 || sb.size() > 0) && cyc < 20) begin
            sel = (idx < 2) ? idx : 0;
            tick(idx < 2, va[sel], vb[sel], 1'b1, 1'b1, 1'b1, acc, got, obs);
            if (acc) idx++;
            if (got) begin
                checks++;
                expv = (sb.size() > 0) ? sb.pop_front() : '1;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL sub_result: got s=%0d co=%b ovf=%b expected s=%0d co=%b ovf=%b",
                             obs.s, obs.co, obs.ovf, expv.s, expv.co, expv.ovf);
                end
                outs++;
            end
            cyc++;
        end
        checks++;
        if (outs != 2) begin
            errors++;
            $display("[TB] FAIL sub_count: got %0d results expected 2", outs);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       acc, got;
        res_t       obs, expv;
        int         idx, sel, outs, cyc;
        va = '{8'd1, 8'd3, 8'd200, 8'd50};
        vb = '{8'd2, 8'd4, 8'd100, 8'd60};
        sb.delete();
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            sel = (idx < 4) ? idx : 0;
            tick(idx < 4, va[sel], vb[sel], 1'b0, 1'b0, 1'b0, acc, got, obs);
            if (acc) idx++;
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || sb.size() == 0 || s !== sb[0].s) begin
                    errors++;
                    $display("[TB] FAIL bp_stall: got out_valid=%b in_ready=%b s=%0d expected 1 0 s=3",
                             out_valid, in_ready, s);
                end
            end
        end
        checks++;
        if (idx != 2) begin
            errors++;
            $display("[TB] FAIL bp_accepted: got %0d beats expected 2", idx);
        end
        outs = 0; cyc = 0;
        while ((idx < 4 || sb.size() > 0) && cyc < 20) begin
            sel = (idx < 4) ? idx : 0;
            tick(idx < 4, va[sel], vb[sel], 1'b0, 1'b0, 1'b1, acc, got, obs);
            if (acc) idx++;
            if (got) begin
                checks++;
                expv = (sb.size() > 0) ? sb.pop_front() : '1;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL bp_result: got s=%0d expected s=%0d", obs.s, expv.s);
                end
                outs++;
            end
            cyc++;
        end
        checks++;
        if (outs != 4) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d results expected 4", outs);
        end
    endtask

    task automatic test_reset_midflight;
        logic acc, got;
        res_t obs, expv;
        int   accepted, outs;
        sb.delete();
        accepted = 0;
        tick(1'b1, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0, acc, got, obs);
        if (acc) accepted++;
        tick(1'b1, 8'd30, 8'd40, 1'b0, 1'b0, 1'b0, acc, got, obs);
        if (acc) accepted++;
        checks++;
        if (accepted != 2) begin
            errors++;
            $display("[TB] FAIL rst_mid_accepted: got %0d expected 2", accepted);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || s !== 8'd0 || skip !== 2'b00 || co !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_state: got out_valid=%b s=%0d skip=%b co=%b in_ready=%b expected 0 0 00 0 1",
                     out_valid, s, skip, co, in_ready);
        end
        @(negedge clk);
        outs = 0;
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc, got, obs);
            if (got) outs++;
        end
        checks++;
        if (outs != 0) begin
            errors++;
            $display("[TB] FAIL rst_mid_ghost: got %0d outputs expected 0", outs);
        end
        tick(1'b1, 8'd7, 8'd8, 1'b0, 1'b0, 1'b1, acc, got, obs);
        outs = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc, got, obs);
            if (got) begin
                checks++;
                expv = (sb.size() > 0) ? sb.pop_front() : '1;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL rst_mid_after: got s=%0d expected s=%0d", obs.s, expv.s);
                end
                outs++;
            end
        end
        checks++;
        if (outs != 1) begin
            errors++;
            $display("[TB] FAIL rst_mid_after_count: got %0d expected 1", outs);
        end
    endtask

    task automatic test_wide_latency;
        int lat;
        w_a = 16'd5; w_b = 16'd10; w_ci = 1'b1; w_sub = 1'b0; w_out_ready = 1'b1;
        w_in_valid = 1'b1;
        #1;
        checks++;
        if (w_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wide_in_ready: got %b expected 1", w_in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        lat = 1;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("[TB] FAIL wide_latency: got %0d expected 4", lat);
        end
        checks++;
        if (w_s !== 16'd16 || w_co !== 1'b0 || w_ovf !== 1'b0 || w_skip !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL wide_result: got s=%0d co=%b ovf=%b skip=%b expected s=16 co=0 ovf=0 skip=0001",
                     w_s, w_co, w_ovf, w_skip);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] ra [40];
        logic [7:0] rb [40];
        logic       rc [40];
        logic       rs [40];
        logic       acc, got, v, rdy;
        res_t       obs, expv;
        int         idx, sel, outs, cyc;
        for (int i = 0; i < 40; i++) begin
            ra[i] = 8'($urandom_range(0, 255));
            rb[i] = 8'($urandom_range(0, 255));
            rc[i] = 1'($urandom_range(0, 1));
            rs[i] = 1'($urandom_range(0, 1));
        end
        sb.delete();
        idx = 0; outs = 0; cyc = 0;
        while ((idx < 40 || sb.size() > 0) && cyc < 400) begin
            sel = (idx < 40) ? idx : 0;
            v   = (idx < 40) && ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            tick(v, ra[sel], rb[sel], rc[sel], rs[sel], rdy, acc, got, obs);
            if (acc) idx++;
            if (got) begin
                checks++;
                expv = (sb.size() > 0) ? sb.pop_front() : '1;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL random_result: got s=%0d co=%b ovf=%b skip=%b expected s=%0d co=%b ovf=%b skip=%b",
                             obs.s, obs.co, obs.ovf, obs.skip, expv.s, expv.co, expv.ovf, expv.skip);
                end
                outs++;
            end
            cyc++;
        end
        checks++;
        if (outs != 40) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d results expected 40", outs);
        end
    endtask

    initial begin
        $display("[TB] carryskip_pipe_adder bench starting");
        test_reset();
        test_basic();
        test_back_to_back();
        test_skip();
        test_subtract();
        test_backpressure();
        test_reset_midflight();
        test_wide_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
